// File: rtl/alu4_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu4_cmd_driver
//
// Sequential initiator for a combinational 4-bit ALU. It accepts commands over a
// valid/ready handshake and keeps a 4-bit accumulator that is always used as
// ALU operand A. An ALU command drives the ALU from registered outputs and
// holds them for SETTLE_CYCLES cycles. It then captures the result into the
// accumulator and the ALU flags into the status register. A load command writes
// the accumulator directly and completes in one cycle.
//
// Parameters:
//   SETTLE_CYCLES  cycles the ALU inputs are held stable before capture (1..15)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   cmd_valid   in   command present
//   cmd_ready   out  driver can accept a command (high in IDLE)
//   cmd_load    in   1: load accumulator with cmd_data, 0: execute ALU op
//   cmd_op      in   ALU opcode (NOT A, NOT B, AND, OR, XOR, XNOR, ADD, SUB)
//   cmd_data    in   operand B, or the load value
//   alu_a       out  registered operand A to the ALU
//   alu_b       out  registered operand B to the ALU
//   alu_op      out  registered opcode to the ALU
//   alu_result  in   ALU result
//   alu_c/n/z/v in   ALU flags
//   acc         out  accumulator
//   flags       out  status register {n, z, c, v}
//   sticky_v    out  sticky overflow (only with ALU4_STICKY_V_EN defined)
//   done        out  one-cycle pulse when a command completes
//
// Optional feature macro: ALU4_STICKY_V_EN
//   When defined, adds sticky_v. It is set by any ALU capture with alu_v = 1.
//   It is cleared by reset or by an accepted load command.
// -----------------------------------------------------------------------------
module alu4_cmd_driver #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [3:0] alu_result,
    input  logic       alu_c,
    input  logic       alu_n,
    input  logic       alu_z,
    input  logic       alu_v,
    output logic [3:0] acc,
    output logic [3:0] flags,
`ifdef ALU4_STICKY_V_EN
    output logic       sticky_v,
`endif
    output logic       done
);

    // FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    // The counter is preloaded with SETTLE_CYCLES-1. Capture happens when it reads
    // zero, so the ALU inputs are stable for exactly SETTLE_CYCLES cycles.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // Out-of-range settle times are rejected while the design is elaborated.
    generate
        if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_settle_range_bad
            $error("alu4_cmd_driver: SETTLE_CYCLES=%0d is outside 1..15", SETTLE_CYCLES);
        end
    endgenerate

    // Status flags after a load: n and z follow the loaded value. c and v keep
    // the result of the most recent ALU capture.
    function automatic logic [3:0] load_flags(input logic [3:0] data,
                                              input logic [3:0] prev);
        logic [3:0] f;
        f[3] = data[3];
        f[2] = (data == 4'h0);
        f[1] = prev[1];
        f[0] = prev[0];
        return f;
    endfunction

    // Status flags after an ALU capture. They are taken verbatim from the ALU and
    // packed as {n, z, c, v}.
    function automatic logic [3:0] capture_flags(input logic n, input logic z,
                                                 input logic c, input logic v);
        return {n, z, c, v};
    endfunction

    // Registered state
    logic [0:0] state_r;
    logic [3:0] cnt_r;
    logic       ready_r;
    logic [3:0] acc_r;
    logic [3:0] flags_r;
    logic [3:0] alu_a_r;
    logic [3:0] alu_b_r;
    logic [2:0] alu_op_r;
    logic       done_r;

    // Next-state values
    logic [0:0] state_s;
    logic [3:0] cnt_s;
    logic       ready_s;
    logic [3:0] acc_s;
    logic [3:0] flags_s;
    logic [3:0] alu_a_s;
    logic [3:0] alu_b_s;
    logic [2:0] alu_op_s;
    logic       done_s;
    logic       accept_s;

`ifdef ALU4_STICKY_V_EN
    logic       sticky_r;
    logic       sticky_s;
`endif

    // Handshake qualifier. cmd_ready is only high in IDLE, so this also gates on state.
    assign accept_s = cmd_valid & ready_r;

    // Next-state logic for the command FSM, datapath registers and done pulse
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        ready_s  = ready_r;
        acc_s    = acc_r;
        flags_s  = flags_r;
        alu_a_s  = alu_a_r;
        alu_b_s  = alu_b_r;
        alu_op_s = alu_op_r;
        done_s   = 1'b0;
`ifdef ALU4_STICKY_V_EN
        sticky_s = sticky_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (cmd_load) begin
                        // A load completes immediately and stays in IDLE, so
                        // loads can be issued back to back.
                        acc_s   = cmd_data;
                        flags_s = load_flags(cmd_data, flags_r);
                        done_s  = 1'b1;
                        ready_s = 1'b1;
`ifdef ALU4_STICKY_V_EN
                        sticky_s = 1'b0;
`endif
                    end else begin
                        // Launch the ALU. Its inputs then stay frozen until capture.
                        alu_a_s  = acc_r;
                        alu_b_s  = cmd_data;
                        alu_op_s = cmd_op;
                        cnt_s    = SETTLE_LOAD;
                        state_s  = ST_DRIVE;
                        ready_s  = 1'b0;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end

            ST_DRIVE: begin
                if (cnt_r != 4'd0) begin
                    cnt_s   = cnt_r - 4'd1;
                    ready_s = 1'b0;
                end else begin
                    // Settle time has elapsed, so take the ALU outputs as they are.
                    // Raising ready here lets the next command be accepted in the
                    // same cycle that done is seen.
                    acc_s   = alu_result;
                    flags_s = capture_flags(alu_n, alu_z, alu_c, alu_v);
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                    ready_s = 1'b1;
`ifdef ALU4_STICKY_V_EN
                    if (alu_v) begin
                        sticky_s = 1'b1;
                    end else begin
                        sticky_s = sticky_r;
                    end
`endif
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean IDLE.
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                ready_s = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            ready_r  <= 1'b1;
            acc_r    <= 4'h0;
            flags_r  <= 4'h0;
            alu_a_r  <= 4'h0;
            alu_b_r  <= 4'h0;
            alu_op_r <= 3'b000;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            ready_r  <= ready_s;
            acc_r    <= acc_s;
            flags_r  <= flags_s;
            alu_a_r  <= alu_a_s;
            alu_b_r  <= alu_b_s;
            alu_op_r <= alu_op_s;
            done_r   <= done_s;
        end
    end

`ifdef ALU4_STICKY_V_EN
    // Sticky overflow register
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= sticky_s;
        end
    end

    assign sticky_v = sticky_r;
`endif

    assign cmd_ready = ready_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign acc       = acc_r;
    assign flags     = flags_r;
    assign done      = done_r;

endmodule

// File: tb/tb_alu4_cmd_driver.sv
// -----------------------------------------------------------------------------
// Testbench for alu4_cmd_driver. Two instances are used, one with
// SETTLE_CYCLES=1 and one with SETTLE_CYCLES=3, each driving a behavioural ALU.
// Expected values come from a transaction-level model of the accumulator and
// status register and from a constant vector table.
// -----------------------------------------------------------------------------
module tb_alu4_cmd_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst3, sel, valid;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;

    logic       rdy1, rdy3, done1, done3;
    logic [3:0] a1, b1, a3, b3, res1, res3, acc1, acc3, flags1, flags3;
    logic [2:0] op1, op3;
    logic       c1, n1, z1, v1, c3, n3, z3, v3;
    logic       valid1, valid3;
`ifdef ALU4_STICKY_V_EN
    logic       sticky1, sticky3, cur_sticky;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural 4-bit ALU returning {result, n, z, c, v}. c is the carry out
    // for ADD and the no-borrow carry for SUB. c and v are 0 for logic ops.
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        s = 5'd0;
        case (op)
            3'd0: r = ~a;
            3'd1: r = ~b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            default: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = s[3:0];
                c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
        endcase
        return {r, r[3], (r == 4'h0), c, v};
    endfunction

    assign {res1, n1, z1, c1, v1} = alu_ref(a1, b1, op1);
    assign {res3, n3, z3, c3, v3} = alu_ref(a3, b3, op3);
    assign valid1 = valid & ~sel;
    assign valid3 = valid & sel;

    alu4_cmd_driver #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst1), .cmd_valid(valid1), .cmd_ready(rdy1),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(a1), .alu_b(b1), .alu_op(op1), .alu_result(res1),
        .alu_c(c1), .alu_n(n1), .alu_z(z1), .alu_v(v1),
        .acc(acc1), .flags(flags1),
`ifdef ALU4_STICKY_V_EN
        .sticky_v(sticky1),
`endif
        .done(done1)
    );

    alu4_cmd_driver #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst3), .cmd_valid(valid3), .cmd_ready(rdy3),
        .cmd_load(cmd_load), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_result(res3),
        .alu_c(c3), .alu_n(n3), .alu_z(z3), .alu_v(v3),
        .acc(acc3), .flags(flags3),
`ifdef ALU4_STICKY_V_EN
        .sticky_v(sticky3),
`endif
        .done(done3)
    );

    // View of the currently selected instance
    logic       cur_ready, cur_done;
    logic [3:0] cur_acc, cur_flags, cur_a, cur_b;
    logic [2:0] cur_op;
    assign cur_ready = sel ? rdy3   : rdy1;
    assign cur_done  = sel ? done3  : done1;
    assign cur_acc   = sel ? acc3   : acc1;
    assign cur_flags = sel ? flags3 : flags1;
    assign cur_a     = sel ? a3     : a1;
    assign cur_b     = sel ? b3     : b1;
    assign cur_op    = sel ? op3    : op1;
`ifdef ALU4_STICKY_V_EN
    assign cur_sticky = sel ? sticky3 : sticky1;
`endif

    // Reference model state per instance (index 0: settle 1, index 1: settle 3)
    int         settle_of [2] = '{1, 3};
    logic [3:0] m_acc [2];
    logic [3:0] m_flags [2];
    logic [3:0] m_a [2];
    logic [3:0] m_b [2];
    logic [2:0] m_op [2];
    logic       m_sticky [2];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s sel=%0d: got %0h expected %0h at %0t", nm, sel, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_acc[i]    = 4'h0;
        m_flags[i]  = 4'h0;
        m_a[i]      = 4'h0;
        m_b[i]      = 4'h0;
        m_op[i]     = 3'd0;
        m_sticky[i] = 1'b0;
    endtask

    // Compare the selected instance against the model while it is idle.
    task automatic check_idle(input string tag);
        int i;
        i = sel ? 1 : 0;
        chk({tag, "_acc"},   8'(cur_acc),   8'(m_acc[i]));
        chk({tag, "_flags"}, 8'(cur_flags), 8'(m_flags[i]));
        chk({tag, "_done"},  8'(cur_done),  8'd0);
        chk({tag, "_ready"}, 8'(cur_ready), 8'd1);
        chk({tag, "_alu_a"}, 8'(cur_a),     8'(m_a[i]));
        chk({tag, "_alu_b"}, 8'(cur_b),     8'(m_b[i]));
        chk({tag, "_alu_op"}, 8'(cur_op),   8'(m_op[i]));
`ifdef ALU4_STICKY_V_EN
        chk({tag, "_sticky"}, 8'(cur_sticky), 8'(m_sticky[i]));
`endif
    endtask

    // Issue one command to the selected instance. Check the busy window and the
    // completion cycle. The task returns at the negedge of the done cycle.
    task automatic run_cmd(input logic ld, input logic [2:0] op, input logic [3:0] d);
        int i, lat, guard;
        logic [7:0] r;
        i = sel ? 1 : 0;
        cmd_load = ld;
        cmd_op   = op;
        cmd_data = d;
        valid    = 1'b1;
        guard    = 0;
        while (!cur_ready && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (!cur_ready) begin
            chk("accept_timeout", 8'(cur_ready), 8'd1);
            valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid    = 1'b0;
        cmd_load = 1'($urandom);
        cmd_op   = 3'($urandom);
        cmd_data = 4'($urandom);
        if (ld) begin
            m_acc[i]    = d;
            m_flags[i]  = {d[3], (d == 4'h0), m_flags[i][1:0]};
            m_sticky[i] = 1'b0;
            lat = 1;
        end else begin
            r = alu_ref(m_acc[i], d, op);
            m_a[i]     = m_acc[i];
            m_b[i]     = d;
            m_op[i]    = op;
            m_acc[i]   = r[7:4];
            m_flags[i] = r[3:0];
            if (r[0]) m_sticky[i] = 1'b1;
            lat = settle_of[i] + 1;
        end
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                chk("busy_done",  8'(cur_done),  8'd0);
                chk("busy_ready", 8'(cur_ready), 8'd0);
                chk("hold_alu_a", 8'(cur_a),     8'(m_a[i]));
                chk("hold_alu_b", 8'(cur_b),     8'(m_b[i]));
                chk("hold_alu_op", 8'(cur_op),   8'(m_op[i]));
            end else begin
                chk("done",       8'(cur_done),  8'd1);
                chk("acc",        8'(cur_acc),   8'(m_acc[i]));
                chk("flags",      8'(cur_flags), 8'(m_flags[i]));
                chk("done_ready", 8'(cur_ready), 8'd1);
                chk("alu_a",      8'(cur_a),     8'(m_a[i]));
                chk("alu_b",      8'(cur_b),     8'(m_b[i]));
                chk("alu_op",     8'(cur_op),    8'(m_op[i]));
`ifdef ALU4_STICKY_V_EN
                chk("sticky_v",   8'(cur_sticky), 8'(m_sticky[i]));
`endif
            end
        end
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [3:0] d;
        logic [3:0] acc;
        logic [3:0] flags;
    } vec_t;

    vec_t vecs [9];

    // Absolute time limit so a stuck design cannot hang the run
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

    initial begin
        //            ld    op     data   acc     flags {n,z,c,v}
        vecs[0] = '{1'b1, 3'd0, 4'h7, 4'h7, 4'b0000};
        vecs[1] = '{1'b0, 3'd6, 4'h7, 4'hE, 4'b1001};
        vecs[2] = '{1'b1, 3'd0, 4'hF, 4'hF, 4'b1001};
        vecs[3] = '{1'b0, 3'd6, 4'hF, 4'hE, 4'b1010};
        vecs[4] = '{1'b1, 3'd0, 4'hF, 4'hF, 4'b1010};
        vecs[5] = '{1'b0, 3'd7, 4'h5, 4'hA, 4'b1010};
        vecs[6] = '{1'b1, 3'd0, 4'h0, 4'h0, 4'b0110};
        vecs[7] = '{1'b0, 3'd0, 4'h0, 4'hF, 4'b1000};
        vecs[8] = '{1'b0, 3'd4, 4'hF, 4'h0, 4'b0100};

        sel = 1'b0; valid = 1'b0; cmd_load = 1'b0; cmd_op = 3'd0; cmd_data = 4'h0;
        rst1 = 1'b1; rst3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0; rst3 = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        check_idle("reset1");
        sel = 1'b1; #1;
        check_idle("reset3");
        sel = 1'b0; #1;

        // Directed vector table on the settle-1 instance
        for (int k = 0; k < 9; k++) begin
            run_cmd(vecs[k].ld, vecs[k].op, vecs[k].d);
            chk("vec_acc",   8'(cur_acc),   8'(vecs[k].acc));
            chk("vec_flags", 8'(cur_flags), 8'(vecs[k].flags));
        end
        @(negedge clk);
        chk("done_one_cycle", 8'(cur_done), 8'd0);

        // Settle 3: ADD accepted at T while a load is held valid behind it
        sel = 1'b1; #1;
        run_cmd(1'b1, 3'd0, 4'h3);
        cmd_load = 1'b0; cmd_op = 3'd6; cmd_data = 4'h4; valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_load = 1'b1; cmd_data = 4'h2;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("hold_ready", 8'(cur_ready), 8'd0);
            chk("hold_done",  8'(cur_done),  8'd0);
            chk("hold_a3",    8'(cur_a),     8'h3);
            chk("hold_b3",    8'(cur_b),     8'h4);
            chk("hold_op3",   8'(cur_op),    8'd6);
        end
        @(negedge clk);
        chk("t4_done",  8'(cur_done),  8'd1);
        chk("t4_acc",   8'(cur_acc),   8'h7);
        chk("t4_flags", 8'(cur_flags), 8'h0);
        chk("t4_ready", 8'(cur_ready), 8'd1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk("held_load_done", 8'(cur_done), 8'd1);
        chk("held_load_acc",  8'(cur_acc),  8'h2);
        @(negedge clk);
        chk("held_load_once", 8'(cur_done), 8'd0);
        m_acc[1] = 4'h2; m_flags[1] = 4'h0; m_a[1] = 4'h3; m_b[1] = 4'h4; m_op[1] = 3'd6;
        m_sticky[1] = 1'b0;

        // Reset one cycle after an ADD handshake (settle 3)
        run_cmd(1'b1, 3'd0, 4'h5);
        cmd_load = 1'b0; cmd_op = 3'd6; cmd_data = 4'h6; valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        rst3  = 1'b1;
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        model_reset(1);
        @(negedge clk);
        check_idle("abort");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort_no_done", 8'(cur_done), 8'd0);
        end

        // Reset and cmd_valid in the same cycle: reset wins (settle 1)
        sel = 1'b0; #1;
        run_cmd(1'b1, 3'd0, 4'h9);
        cmd_load = 1'b1; cmd_data = 4'hA; valid = 1'b1; rst1 = 1'b1;
        @(posedge clk);
        #1;
        rst1 = 1'b0; valid = 1'b0;
        model_reset(0);
        @(negedge clk);
        check_idle("rst_vs_cmd");
        @(negedge clk);
        chk("rst_vs_cmd_no_done", 8'(cur_done), 8'd0);

        // Sticky overflow sequences (the checks inside run_cmd compare sticky_v
        // when the feature is built in)
        run_cmd(1'b1, 3'd0, 4'h7);
        run_cmd(1'b0, 3'd6, 4'h7);
        run_cmd(1'b1, 3'd0, 4'h3);
        run_cmd(1'b0, 3'd6, 4'h3);
        chk("sticky_seq_acc", 8'(cur_acc), 8'h6);
        run_cmd(1'b1, 3'd0, 4'h7);
        run_cmd(1'b0, 3'd6, 4'h7);
        run_cmd(1'b0, 3'd6, 4'h1);
        chk("sticky_seq2_acc", 8'(cur_acc), 8'hF);
`ifdef ALU4_STICKY_V_EN
        chk("sticky_kept", 8'(cur_sticky), 8'd1);
`endif

        // Randomized commands on both instances, with idle gaps carrying junk data
        for (int n = 0; n < 150; n++) begin
            sel = 1'($urandom_range(0, 1));
            #1;
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                cmd_load = 1'($urandom); cmd_op = 3'($urandom); cmd_data = 4'($urandom);
                @(negedge clk);
                check_idle("gap");
            end
            run_cmd(1'($urandom_range(0, 3) == 0), 3'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu4_cmd_driver.md
Name: alu4_cmd_driver

Overview:
- Sequential initiator for the combinational 4-bit ALU (a, b, op in; result, c, n, z, v out).
- Accepts commands over a valid/ready handshake and keeps a 4-bit accumulator that is always used as ALU operand A.
- Drives the ALU from registered outputs, waits a programmable settle time, then captures the result into the accumulator and the flags into a status register.
- Sits between a simple controller/sequencer and the ALU instance.

Parameters:
- SETTLE_CYCLES, 1, number of cycles ALU inputs are held stable before capture. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command.
- cmd_load  input  1  1: load accumulator with cmd_data; 0: execute ALU op.
- cmd_op  input  3  ALU opcode. 000 NOT A, 001 NOT B, 010 AND, 011 OR, 100 XOR, 101 XNOR, 110 ADD, 111 SUB.
- cmd_data  input  4  operand B, or the load value.
- alu_a  output  4  registered operand A to the ALU.
- alu_b  output  4  registered operand B to the ALU.
- alu_op  output  3  registered opcode to the ALU.
- alu_result  input  4  ALU result.
- alu_c, alu_n, alu_z, alu_v  input  1 each  ALU flags.
- acc  output  4  accumulator.
- flags  output  4  status register {n, z, c, v}.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (synchronous, active-high):
  - acc = 0, flags = 0, alu_a = 0, alu_b = 0, alu_op = 0, done = 0.
  - cmd_ready = 1, state = IDLE, settle counter = 0.
- States:
  - IDLE: cmd_ready = 1.
  - DRIVE: cmd_ready = 0.
- IDLE, accept on cmd_valid & cmd_ready at edge T, load command (cmd_load = 1):
  - acc <= cmd_data.
  - flags.n <= cmd_data[3]; flags.z <= (cmd_data == 0); flags.c and flags.v unchanged.
  - done = 1 in cycle T+1; state stays IDLE. Back-to-back loads are allowed every cycle.
- IDLE, accept, ALU command (cmd_load = 0):
  - alu_a <= acc, alu_b <= cmd_data, alu_op <= cmd_op.
  - counter <= SETTLE_CYCLES-1; go to DRIVE.
- DRIVE:
  - alu_a, alu_b and alu_op are held constant.
  - If counter != 0, decrement. If counter == 0, then acc <= alu_result, flags <= {alu_n, alu_z, alu_c, alu_v}, done <= 1, go to IDLE.
- Latency, command accepted at edge T:
  - acc, flags and done are valid in cycle T+SETTLE_CYCLES+1.
  - cmd_ready is low for cycles T+1 .. T+SETTLE_CYCLES.
  - cmd_ready is high again in the same cycle as done, so the next command can be accepted at that edge.
- Flags are captured verbatim from the ALU. The driver never recomputes or masks c, n, z or v for ALU commands.
- cmd_op, cmd_data and cmd_load are ignored unless the handshake occurs. cmd_valid while in DRIVE is held off, not dropped; the source keeps it asserted.
- alu_a/b/op keep their last values in IDLE (no toggling when idle).
- Reset mid-DRIVE: the operation is aborted, no done pulse, acc and flags return to 0.
- reset and cmd_valid asserted in the same cycle: reset wins and the command is not accepted.
- SETTLE_CYCLES outside 1..15 is illegal; it is flagged by a simulation-only check at elaboration.

Optional Feature:
- Macro: ALU4_STICKY_V_EN.
- Defined:
  - Adds output port sticky_v (1 bit, reset 0).
  - Set on any ALU capture with alu_v = 1.
  - Cleared only by reset or by an accepted load command.
  - A capture with v = 0 leaves it unchanged.
- Undefined: port and logic are absent; flags.v still reflects the most recent capture.

Test Plan:
- SETTLE_CYCLES=1, ALU instance attached:
  - Load 4'h7, then ADD 4'h7 → acc = 4'b1110, flags = {1,0,0,1}.
  - done appears 2 cycles after the ADD handshake.
- Load 4'hF, ADD 4'hF → acc = 4'b1110, flags = {1,0,1,0}.
- Then load 4'hF, SUB 4'h5 → acc = 4'b1010, flags = {1,0,1,0}.
- Load 4'h0, then NOT A → acc = 4'b1111, n = 1, z = 0.
- Then XOR 4'b1111 → acc = 4'b0000, z = 1.
- SETTLE_CYCLES=3, ADD accepted at edge T:
  - cmd_ready is low for exactly 3 cycles; alu_a/b/op are stable throughout.
  - done and the new acc appear at T+4.
  - A second command held valid is accepted on the done cycle.
- Reset asserted one cycle after an ADD handshake with SETTLE_CYCLES=3:
  - No done pulse; acc = 0 and flags = 0 next cycle; cmd_ready = 1.
- ALU4_STICKY_V_EN defined:
  - 7+7 (v = 1), then load 3, 3+3 (v = 0) → sticky_v goes 1, then 0 after the load, and stays 0 after 3+3.
  - Without the load between them, sticky_v stays 1.
